// File: rtl/uart_frame_pkg.sv
`timescale 1ns/1ps
// uart_frame_pkg: shared state encoding and default frame constants for the
// UART command-frame parser and its gap timer.
package uart_frame_pkg;

  // Parser states; 3-bit encoding shared by the parser and anything observing it.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Payload bytes per frame (o_Block is 8x this wide).
  localparam int         DEF_BLOCK_BYTES  = 16;
  // Start-of-frame marker.
  localparam logic [7:0] DEF_SOF_BYTE     = 8'hA5;
  // Roughly 20 bit times at 9600 baud with a 100 MHz clock.
  localparam int         DEF_TIMEOUT_CLKS = 208320;

endpackage

// File: rtl/uart_gap_timer.sv
`timescale 1ns/1ps
// uart_gap_timer: counts idle clocks between received bytes while a frame is
// being assembled and raises a one-cycle expire pulse when the gap reaches
// TIMEOUT_CLKS. A clear in the same cycle as the would-be expiry wins.
module uart_gap_timer
  import uart_frame_pkg::*;
#(
  parameter int TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Clear,
  input  logic i_Enable,
  output logic o_Expire
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CLKS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);

  logic [CNT_W-1:0] r_count;

  // Expire only when the count is at its last value and no byte arrived this cycle.
  assign o_Expire = i_Enable && !i_Clear && (r_count == CNT_LAST);

  // Gap counter: held at zero outside a frame, restarted by every received byte.
  always_ff @(posedge i_Clock) begin
    if (i_Reset || i_Clear || !i_Enable || o_Expire) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_frame_parser.sv
`timescale 1ns/1ps
// uart_frame_parser: assembles SOF, CMD, BLOCK_BYTES payload [, XOR checksum]
// frames from the UART receiver byte stream and hands the command plus the
// payload block to the crypto loading logic with a one-cycle valid pulse.
// Frames that stall (inter-byte gap) or fail the checksum are dropped with a
// one-cycle error pulse.
// Build option: define UART_FRAME_CSUM_EN to append and verify a checksum byte;
// without it the frame ends after the payload and o_Csum_Err is tied low.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int         BLOCK_BYTES  = DEF_BLOCK_BYTES,
  parameter logic [7:0] SOF_BYTE     = DEF_SOF_BYTE,
  parameter int         TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
  input  logic                     i_Clock,
  input  logic                     i_Reset,
  input  logic                     i_Rx_DV,
  input  logic [7:0]               i_Rx_Byte,
  output logic [7:0]               o_Cmd,
  output logic [8*BLOCK_BYTES-1:0] o_Block,
  output logic                     o_Block_DV,
  output logic                     o_Csum_Err,
  output logic                     o_Timeout_Err,
  output logic                     o_Busy
);

  localparam int               BW       = 8 * BLOCK_BYTES;
  localparam int               IDX_W    = $clog2(BLOCK_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_BYTES - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_cmd_shadow;
  logic [BW-1:0]    r_block_shadow;
  logic [7:0]       r_cmd;
  logic [BW-1:0]    r_block;
  logic             r_block_dv;
  logic             r_timeout_err;
`ifdef UART_FRAME_CSUM_EN
  logic [7:0]       r_csum;
  logic             r_csum_err;
`endif

  logic w_gap_en;
  logic w_gap_expire;

  // The gap timer only runs while waiting for bytes of a frame in progress.
  assign w_gap_en = (r_state == S_CMD) || (r_state == S_DATA) || (r_state == S_CSUM);

  uart_gap_timer #(
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) u_gap_timer (
    .i_Clock  (i_Clock),
    .i_Reset  (i_Reset),
    .i_Clear  (i_Rx_DV),
    .i_Enable (w_gap_en),
    .o_Expire (w_gap_expire)
  );

  // Frame FSM with registered outputs; a stall abandons the frame from any active state.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_state        <= S_IDLE;
      r_idx          <= '0;
      r_cmd_shadow   <= '0;
      r_block_shadow <= '0;
      r_cmd          <= '0;
      r_block        <= '0;
      r_block_dv     <= 1'b0;
      r_timeout_err  <= 1'b0;
`ifdef UART_FRAME_CSUM_EN
      r_csum         <= '0;
      r_csum_err     <= 1'b0;
`endif
    end else begin
      r_block_dv    <= 1'b0;
      r_timeout_err <= 1'b0;
`ifdef UART_FRAME_CSUM_EN
      r_csum_err    <= 1'b0;
`endif
      if (w_gap_expire) begin
        r_timeout_err <= 1'b1;
        r_state       <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_Rx_DV && (i_Rx_Byte == SOF_BYTE)) begin
              r_state <= S_CMD;
            end
          end
          S_CMD: begin
            if (i_Rx_DV) begin
              r_cmd_shadow <= i_Rx_Byte;
`ifdef UART_FRAME_CSUM_EN
              r_csum       <= i_Rx_Byte;
`endif
              r_idx        <= '0;
              r_state      <= S_DATA;
            end
          end
          S_DATA: begin
            if (i_Rx_DV) begin
              // First payload byte ends up in the most significant lane.
              r_block_shadow <= {r_block_shadow[BW-9:0], i_Rx_Byte};
`ifdef UART_FRAME_CSUM_EN
              r_csum         <= r_csum ^ i_Rx_Byte;
`endif
              r_idx          <= r_idx + 1'b1;
              if (r_idx == LAST_IDX) begin
`ifdef UART_FRAME_CSUM_EN
                r_state <= S_CSUM;
`else
                r_state <= S_DONE;
`endif
              end
            end
          end
`ifdef UART_FRAME_CSUM_EN
          S_CSUM: begin
            if (i_Rx_DV) begin
              if (i_Rx_Byte == r_csum) begin
                r_state <= S_DONE;
              end else begin
                r_csum_err <= 1'b1;
                r_state    <= S_IDLE;
              end
            end
          end
`endif
          S_DONE: begin
            r_cmd      <= r_cmd_shadow;
            r_block    <= r_block_shadow;
            r_block_dv <= 1'b1;
            r_state    <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_Cmd         = r_cmd;
  assign o_Block       = r_block;
  assign o_Block_DV    = r_block_dv;
  assign o_Timeout_Err = r_timeout_err;
  assign o_Busy        = (r_state != S_IDLE);
`ifdef UART_FRAME_CSUM_EN
  assign o_Csum_Err    = r_csum_err;
`else
  assign o_Csum_Err    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_frame_parser.sv
`timescale 1ns/1ps
// tb_uart_frame_parser: randomized byte-stream stimulus, frame-level reference
// model feeding an expectation queue, and an independent output monitor.
module tb_uart_frame_parser;

  localparam int         BB  = 16;
  localparam logic [7:0] SOF = 8'hA5;
  localparam int         T   = 40;
`ifdef UART_FRAME_CSUM_EN
  localparam int         REST = BB + 2;   // CMD + payload + checksum after SOF
`else
  localparam int         REST = BB + 1;   // CMD + payload after SOF
`endif

  typedef struct {
    int           kind;   // 1 = good frame, 2 = checksum error, 3 = timeout
    logic [7:0]   cmd;
    logic [127:0] blk;
    int           cyc;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         rx_dv;
  logic [7:0]   rx_byte;
  logic [7:0]   o_Cmd;
  logic [127:0] o_Block;
  logic         o_Block_DV;
  logic         o_Csum_Err;
  logic         o_Timeout_Err;
  logic         o_Busy;

  int   cyc;
  int   n_checks;
  int   n_pass;
  exp_t sb[$];

  // Reference model state: frame-level view of the byte stream.
  bit           in_frame;
  logic [7:0]   fq[$];
  int           last_dv_edge;
  int           done_edge;
  logic [7:0]   exp_cmd;
  logic [127:0] exp_blk;

  uart_frame_parser #(
    .BLOCK_BYTES  (BB),
    .SOF_BYTE     (SOF),
    .TIMEOUT_CLKS (T)
  ) dut (
    .i_Clock       (clk),
    .i_Reset       (rst),
    .i_Rx_DV       (rx_dv),
    .i_Rx_Byte     (rx_byte),
    .o_Cmd         (o_Cmd),
    .o_Block       (o_Block),
    .o_Block_DV    (o_Block_DV),
    .o_Csum_Err    (o_Csum_Err),
    .o_Timeout_Err (o_Timeout_Err),
    .o_Busy        (o_Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %h required %h", name, act, req);
  endtask

  // Model: one received byte, sampled at clock edge edge_n.
  task automatic model_byte(input logic [7:0] b, input int edge_n);
    logic [7:0]   x;
    logic [127:0] blk;
    exp_t         e;
    bit           ok;
    if (edge_n == done_edge) return;           // arrives while the frame is being delivered
    if (!in_frame) begin
      if (b == SOF) begin
        in_frame     = 1'b1;
        fq.delete();
        last_dv_edge = edge_n;
      end
      return;
    end
    last_dv_edge = edge_n;
    fq.push_back(b);
    if (fq.size() == REST) begin
      x = 8'h00;
      for (int i = 0; i <= BB; i++) x = x ^ fq[i];
      blk = '0;
      for (int i = 0; i < BB; i++) blk[127-8*i -: 8] = fq[i+1];
      ok = 1'b1;
`ifdef UART_FRAME_CSUM_EN
      ok = (fq[BB+1] == x);
`endif
      in_frame = 1'b0;
      e.cmd = fq[0];
      e.blk = blk;
      if (ok) begin
        e.kind    = 1;
        e.cyc     = edge_n + 1;
        exp_cmd   = fq[0];
        exp_blk   = blk;
        done_edge = edge_n + 1;
      end else begin
        e.kind = 2;
        e.cyc  = edge_n;
      end
      sb.push_back(e);
    end
  endtask

  // One clock with no byte; the model predicts a stall on the edge it reaches.
  task automatic idle_cycle();
    exp_t e;
    if (in_frame && (cyc + 1 == last_dv_edge + T)) begin
      e.kind = 3; e.cmd = '0; e.blk = '0; e.cyc = cyc + 1;
      sb.push_back(e);
      in_frame = 1'b0;
    end
    rx_dv = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int i = 0; i < gap; i++) idle_cycle();
    rx_dv   = 1'b1;
    rx_byte = b;
    model_byte(b, cyc + 1);
    @(posedge clk); #1;
    rx_dv   = 1'b0;
    rx_byte = $urandom_range(0, 255);
  endtask

  function automatic logic [7:0] xsum(input logic [7:0] cmd, input logic [127:0] blk);
    logic [7:0] x;
    x = cmd;
    for (int i = 0; i < BB; i++) x = x ^ blk[127-8*i -: 8];
    return x;
  endfunction

  // Whole frame; byte index long_at (0 = CMD) is preceded by long_gap idle clocks.
  task automatic send_frame(input logic [7:0] cmd, input logic [127:0] blk,
                            input logic [7:0] csum, input int long_at, input int long_gap);
    int g;
    send_byte(SOF, $urandom_range(0, 2));
    for (int j = 0; j < REST; j++) begin
      g = (j == long_at) ? long_gap : int'($urandom_range(0, 2));
      if (j == 0)        send_byte(cmd, g);
      else if (j <= BB)  send_byte(blk[127-8*(j-1) -: 8], g);
      else               send_byte(csum, g);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    in_frame  = 1'b0;
    fq.delete();
    done_edge = -1;
    exp_cmd   = '0;
    exp_blk   = '0;
  endtask

  // Monitor: every output pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    int   act_kind;
    exp_t e;
    if (!rst && (o_Block_DV || o_Csum_Err || o_Timeout_Err)) begin
      case ({o_Block_DV, o_Csum_Err, o_Timeout_Err})
        3'b100:  act_kind = 1;
        3'b010:  act_kind = 2;
        3'b001:  act_kind = 3;
        default: act_kind = 7;
      endcase
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 128'(act_kind), 128'd0);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", 128'(act_kind), 128'(e.kind));
        if (e.kind == 1) begin
          chk("frame_cmd", 128'(o_Cmd), 128'(e.cmd));
          chk("frame_block", o_Block, e.blk);
          chk("frame_latency", 128'(cyc), 128'(e.cyc));
        end else if (e.kind == 3) begin
          chk("timeout_cycle", 128'(cyc), 128'(e.cyc));
        end
        $display("txn kind=%0d cmd=%h block=%h cyc=%0d", act_kind, o_Cmd, o_Block, cyc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, actual running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] blk;
    logic [7:0]   cmd;
    logic [7:0]   cs;
    logic [7:0]   junk;
    int           la;
    int           lg;
    n_checks  = 0;
    n_pass    = 0;
    in_frame  = 1'b0;
    done_edge = -1;
    last_dv_edge = 0;
    exp_cmd   = '0;
    exp_blk   = '0;
    rst       = 1'b1;
    rx_dv     = 1'b0;
    rx_byte   = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("reset_busy", 128'(o_Busy), 128'd0);
    chk("reset_cmd", 128'(o_Cmd), 128'd0);
    chk("reset_block", o_Block, 128'd0);
    chk("reset_pulses", 128'({o_Block_DV, o_Csum_Err, o_Timeout_Err}), 128'd0);

    // Known frame: cmd 01, payload 00..0F, checksum 01
    send_frame(8'h01, 128'h000102030405060708090A0B0C0D0E0F, 8'h01, -1, 0);
    repeat (4) idle_cycle();
    chk("t1_cmd_hold", 128'(o_Cmd), 128'h01);

`ifdef UART_FRAME_CSUM_EN
    // Same frame with a wrong checksum: error, previous payload kept
    send_frame(8'h01, 128'h000102030405060708090A0B0C0D0E0F, 8'h00, -1, 0);
    repeat (4) idle_cycle();
    chk("t2_block_hold", o_Block, 128'h000102030405060708090A0B0C0D0E0F);
    chk("t2_busy", 128'(o_Busy), 128'd0);
`endif

    // Junk before SOF is dropped
    send_byte(8'h3C, 1);
    send_byte(8'h7E, 0);
    blk = 128'hFFEEDDCCBBAA99887766554433221100;
    send_frame(8'h5A, blk, xsum(8'h5A, blk), -1, 0);
    repeat (4) idle_cycle();

    // Stall after 5 payload bytes, then a good frame
    send_byte(SOF, 1);
    send_byte(8'h02, 0);
    for (int i = 0; i < 5; i++) send_byte(8'(i * 17), 0);
    repeat (T + 5) idle_cycle();
    chk("t4_busy", 128'(o_Busy), 128'd0);
    send_frame(8'h01, 128'h000102030405060708090A0B0C0D0E0F, 8'h01, -1, 0);
    repeat (4) idle_cycle();

    // Byte arrives on the exact timeout edge: frame completes
    blk = 128'hA5A5_0000_1111_2222_3333_4444_5555_A5A5;
    send_frame(8'h33, blk, xsum(8'h33, blk), 6, T - 1);
    repeat (4) idle_cycle();

    // Reset after byte 8 of a frame
    send_byte(SOF, 1);
    send_byte(8'h44, 0);
    for (int i = 0; i < 6; i++) send_byte(8'(i + 8'h60), 1);
    pulse_reset();
    chk("t6_cmd", 128'(o_Cmd), 128'd0);
    chk("t6_block", o_Block, 128'd0);
    chk("t6_busy", 128'(o_Busy), 128'd0);
    repeat (T + 5) idle_cycle();
    send_frame(8'h66, 128'h0123456789ABCDEF_FEDCBA9876543210, xsum(8'h66, 128'h0123456789ABCDEF_FEDCBA9876543210), -1, 0);
    repeat (4) idle_cycle();

    // Randomized stream: junk, random frames, occasional stalls and bad checksums
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
          junk = 8'($urandom_range(0, 255));
          if (junk == SOF) junk = 8'h00;
          send_byte(junk, $urandom_range(0, 2));
        end
      end
      cmd = 8'($urandom_range(0, 255));
      blk = {$urandom, $urandom, $urandom, $urandom};
      cs  = xsum(cmd, blk);
      if ($urandom_range(0, 7) == 0) cs = cs ^ 8'($urandom_range(1, 255));
      la = -1;
      lg = 0;
      if ($urandom_range(0, 5) == 0) begin
        la = $urandom_range(0, REST - 1);
        case ($urandom_range(0, 2))
          0:       lg = T - 1;
          1:       lg = T;
          default: lg = T + 3;
        endcase
      end
      send_frame(cmd, blk, cs, la, lg);
    end

    repeat (T + 10) idle_cycle();
    chk("final_queue_empty", 128'(sb.size()), 128'd0);
    chk("final_busy", 128'(o_Busy), 128'd0);
    chk("final_cmd", 128'(o_Cmd), 128'(exp_cmd));
    chk("final_block", o_Block, exp_blk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
